// File: rtl/tea_de_seq.sv
// Block sequencer for the TEA decryption round core: accepts ciphertext+key,
// strobes the core, counts rounds and buffers plaintext in a 2-entry FIFO.
module tea_de_seq #(
   parameter int unsigned ROUNDS = 32,
   parameter logic [31:0] DELTA  = 32'h9E3779B9,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [63:0]       in_data,
   input  logic [127:0]      in_key,
   output logic              core_start,
   output logic [31:0]       core_y,
   output logic [31:0]       core_z,
   output logic [127:0]      core_key,
   output logic [31:0]       core_delta,
   input  logic [63:0]       core_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [63:0]       out_data,
   output logic              busy,
   output logic [CNT_W-1:0]  blk_cnt
);

   localparam int unsigned RND_W = $clog2(ROUNDS + 1);
   localparam logic [RND_W-1:0] RND_LAST = RND_W'(ROUNDS);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;

   logic [1:0]       state;
   logic [RND_W-1:0] rnd;
   logic [63:0]      fifo_mem [0:1];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       fifo_cnt;
   logic             push;
   logic             pop;

   // Only one block is ever in flight, so a free slot at accept is a reserved slot.
   assign in_ready   = !rst && (state == S_IDLE) && (fifo_cnt < 2'd2);
   assign core_start = (state == S_LOAD);
   assign core_delta = DELTA;
   assign busy       = (state != S_IDLE);
   assign out_valid  = (fifo_cnt != 2'd0);
   assign out_data   = fifo_mem[rd_ptr];
   assign push       = (state == S_RUN) && (rnd == RND_LAST);
   assign pop        = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         rnd      <= '0;
         core_y   <= '0;
         core_z   <= '0;
         core_key <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         fifo_cnt <= '0;
         blk_cnt  <= '0;
         for (int unsigned i = 0; i < 2; i++) begin
            fifo_mem[i] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  core_y   <= in_data[63:32];
                  core_z   <= in_data[31:0];
                  core_key <= in_key;
                  state    <= S_LOAD;
               end
            end
            S_LOAD: begin
               rnd   <= '0;
               state <= S_RUN;
            end
            S_RUN: begin
               if (push) begin
                  rnd   <= '0;
                  state <= S_IDLE;
               end else begin
                  rnd <= rnd + RND_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase

         if (push) begin
            fifo_mem[wr_ptr] <= core_data;
            wr_ptr           <= ~wr_ptr;
            blk_cnt          <= blk_cnt + CNT_W'(1);
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_tea_de_seq.sv
// Bench for tea_de_seq: behavioural TEA round core, reference decryptor and
// a scoreboard of expected plaintexts checked as the FIFO drains.
module tb_tea_de_seq;

   localparam int unsigned ROUNDS = 32;
   localparam logic [31:0] DELTA  = 32'h9E3779B9;
   localparam int unsigned CNT_W  = 4;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [63:0]       in_data;
   logic [127:0]      in_key;
   logic              core_start;
   logic [31:0]       core_y;
   logic [31:0]       core_z;
   logic [127:0]      core_key;
   logic [31:0]       core_delta;
   logic [63:0]       core_data;
   logic              out_valid;
   logic              out_ready;
   logic [63:0]       out_data;
   logic              busy;
   logic [CNT_W-1:0]  blk_cnt;

   int                checks = 0;
   int                failures = 0;
   logic [63:0]       sb [$];
   logic [CNT_W-1:0]  exp_cnt = '0;

   tea_de_seq #(.ROUNDS(ROUNDS), .DELTA(DELTA), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_key(in_key), .core_start(core_start),
      .core_y(core_y), .core_z(core_z), .core_key(core_key),
      .core_delta(core_delta), .core_data(core_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .busy(busy), .blk_cnt(blk_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] tea_round(input logic [31:0] y, input logic [31:0] z,
                                             input logic [31:0] sum, input logic [127:0] k);
      logic [31:0] yy;
      logic [31:0] zz;
      yy = y;
      zz = z;
      zz = zz - ((((yy << 4) + k[63:32]) ^ (yy + sum) ^ ((yy >> 5) + k[31:0])));
      yy = yy - ((((zz << 4) + k[127:96]) ^ (zz + sum) ^ ((zz >> 5) + k[95:64])));
      return {yy, zz};
   endfunction

   function automatic logic [63:0] tea_dec(input logic [63:0] d, input logic [127:0] k);
      logic [63:0] v;
      logic [31:0] sum;
      v   = d;
      sum = 32'(DELTA * ROUNDS);
      for (int i = 0; i < int'(ROUNDS); i++) begin
         v   = tea_round(v[63:32], v[31:0], sum, k);
         sum = sum - DELTA;
      end
      return v;
   endfunction

   // Round core model: loads on core_start, one round per following clock.
   logic [31:0] cm_y = '0;
   logic [31:0] cm_z = '0;
   logic [31:0] cm_sum = '0;
   int unsigned cm_cnt = ROUNDS;

   always @(posedge clk) begin
      if (core_start) begin
         cm_y   <= core_y;
         cm_z   <= core_z;
         cm_sum <= 32'(DELTA * ROUNDS);
         cm_cnt <= 0;
      end else if (cm_cnt < ROUNDS) begin
         {cm_y, cm_z} <= tea_round(cm_y, cm_z, cm_sum, core_key);
         cm_sum       <= cm_sum - DELTA;
         cm_cnt       <= cm_cnt + 1;
      end
   end
   assign core_data = {cm_y, cm_z};

   task automatic send_block(input logic [63:0] d, input logic [127:0] k, input int budget,
                             output bit ok);
      in_data  = d;
      in_key   = k;
      in_valid = 1'b1;
      ok       = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) begin
         @(negedge clk);
         sb.push_back(tea_dec(d, k));
         exp_cnt = exp_cnt + 1'b1;
      end
      in_valid = 1'b0;
   endtask

   task automatic pop_one(input int budget, output logic [63:0] data, output bit ok);
      ok   = 1'b0;
      data = '0;
      for (int i = 0; i < budget; i++) begin
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) begin
         data      = out_data;
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_data = '0;
      in_key = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({out_valid, core_start, busy, in_ready} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=0000", {out_valid, core_start, busy, in_ready});
      end
      checks++;
      if (blk_cnt !== '0 || out_data !== '0) begin
         failures++;
         $display("FAIL reset_regs got blk_cnt=%0d out_data=%h exp 0/0", blk_cnt, out_data);
      end
      checks++;
      if (core_y !== '0 || core_z !== '0 || core_key !== '0) begin
         failures++;
         $display("FAIL reset_latches got y=%h z=%h key=%h exp 0", core_y, core_z, core_key);
      end
      checks++;
      if (core_delta !== 32'h9E3779B9) begin
         failures++;
         $display("FAIL core_delta got=%h exp=9e3779b9", core_delta);
      end
      rst = 1'b0;
      exp_cnt = '0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL ready_after_reset got=%b exp=1", in_ready);
      end
   endtask

   task automatic test_latency();
      int lat;
      int starts;
      logic [63:0] got;
      bit ok;
      in_data  = 64'h41EA3A0A_94BAA940;
      in_key   = '0;
      in_valid = 1'b1;
      @(posedge clk);
      lat = 1;
      sb.push_back(tea_dec(in_data, in_key));
      exp_cnt = exp_cnt + 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (core_start !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL load_strobe got start=%b busy=%b exp 1/1", core_start, busy);
      end
      starts = 0;
      while (!out_valid && lat < int'(ROUNDS) + 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (core_start) starts++;
      end
      // Accept cycle counts as cycle 1.
      checks++;
      if (lat != int'(ROUNDS) + 3) begin
         failures++;
         $display("FAIL latency got=%0d exp=%0d", lat, ROUNDS + 3);
      end
      checks++;
      if (starts != 0) begin
         failures++;
         $display("FAIL extra_core_start got=%0d exp=0", starts);
      end
      checks++;
      if (out_data !== 64'h0 || blk_cnt !== CNT_W'(1)) begin
         failures++;
         $display("FAIL vector0 got data=%h cnt=%0d exp data=0 cnt=1", out_data, blk_cnt);
      end
      pop_one(5, got, ok);
      checks++;
      if (!ok || got !== sb[0]) begin
         failures++;
         $display("FAIL vector0_pop got=%h ok=%0d exp=%h", got, ok, sb[0]);
      end
      void'(sb.pop_front());
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL empty_after_pop got=%b exp=0", out_valid);
      end
   endtask

   task automatic test_fill();
      bit ok;
      int hits;
      logic [63:0] got;
      logic [63:0] c_data;
      logic [127:0] c_key;
      out_ready = 1'b0;
      send_block({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 5, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL fill_accept_a got=timeout exp=accept"); end
      send_block({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 100, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL fill_accept_b got=timeout exp=accept"); end
      for (int i = 0; i < 100 && busy; i++) @(negedge clk);
      c_data   = {$urandom, $urandom};
      c_key    = {$urandom, $urandom, $urandom, $urandom};
      in_data  = c_data;
      in_key   = c_key;
      in_valid = 1'b1;
      hits = 0;
      for (int i = 0; i < 10; i++) begin
         if (in_ready) hits++;
         @(negedge clk);
      end
      checks++;
      if (hits != 0 || busy !== 1'b0 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL full_backpressure got ready_cycles=%0d busy=%b ov=%b exp 0/0/1", hits, busy, out_valid);
      end
      got = out_data;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (got !== sb[0]) begin
         failures++;
         $display("FAIL fill_pop_a got=%h exp=%h", got, sb[0]);
      end
      void'(sb.pop_front());
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL ready_after_pop got=%b exp=1", in_ready);
      end
      send_block(c_data, c_key, 5, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL fill_accept_c got=timeout exp=accept"); end
      for (int n = 0; n < 2; n++) begin
         pop_one(100, got, ok);
         checks++;
         if (!ok || sb.size() == 0 || got !== sb[0]) begin
            failures++;
            $display("FAIL fill_pop_%0d got=%h ok=%0d exp=%h", n, got, ok, sb[0]);
         end
         if (sb.size() != 0) void'(sb.pop_front());
      end
   endtask

   task automatic test_simul();
      bit ok;
      logic [63:0] got;
      send_block({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 5, ok);
      for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
      in_data  = {$urandom, $urandom};
      in_key   = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1;
      checks++;
      if (!ok || in_ready !== 1'b1 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL simul_setup got ok=%0d ready=%b ov=%b exp 1/1/1", ok, in_ready, out_valid);
      end
      @(posedge clk);
      sb.push_back(tea_dec(in_data, in_key));
      exp_cnt = exp_cnt + 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (ROUNDS + 1) @(negedge clk);
      got = out_data;
      checks++;
      if (busy !== 1'b1 || got !== sb[0]) begin
         failures++;
         $display("FAIL simul_pre got busy=%b data=%h exp busy=1 data=%h", busy, got, sb[0]);
      end
      void'(sb.pop_front());
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b1 || out_data !== sb[0]) begin
         failures++;
         $display("FAIL simul_post got busy=%b ov=%b data=%h exp 0/1/%h", busy, out_valid, out_data, sb[0]);
      end
      pop_one(5, got, ok);
      checks++;
      if (!ok || got !== sb[0] || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL simul_single got=%h ov=%b exp=%h ov=0", got, out_valid, sb[0]);
      end
      void'(sb.pop_front());
   endtask

   task automatic test_reset_mid();
      int seen;
      in_data  = {$urandom, $urandom};
      in_key   = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (11) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || blk_cnt === '0) begin
         failures++;
         $display("FAIL mid_pre got busy=%b cnt=%0d exp busy=1 cnt!=0", busy, blk_cnt);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || blk_cnt !== '0) begin
         failures++;
         $display("FAIL mid_reset got busy=%b ov=%b cnt=%0d exp 0/0/0", busy, out_valid, blk_cnt);
      end
      rst = 1'b0;
      exp_cnt = '0;
      seen = 0;
      for (int i = 0; i < int'(ROUNDS) + 10; i++) begin
         if (out_valid || core_start || busy) seen++;
         @(negedge clk);
      end
      checks++;
      if (seen != 0 || blk_cnt !== '0) begin
         failures++;
         $display("FAIL mid_dropped got activity=%0d cnt=%0d exp 0/0", seen, blk_cnt);
      end
   endtask

   task automatic test_sample();
      bit ok;
      logic [63:0] got;
      send_block({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 5, ok);
      in_data = ~in_data;
      in_key  = {$urandom, $urandom, $urandom, $urandom};
      repeat (8) @(negedge clk);
      in_data = {$urandom, $urandom};
      pop_one(100, got, ok);
      checks++;
      if (!ok || got !== sb[0]) begin
         failures++;
         $display("FAIL sampled_inputs got=%h ok=%0d exp=%h", got, ok, sb[0]);
      end
      void'(sb.pop_front());
   endtask

   task automatic test_back_to_back();
      int acc;
      int last;
      bit took;
      out_ready = 1'b1;
      in_data   = {$urandom, $urandom};
      in_key    = {$urandom, $urandom, $urandom, $urandom};
      in_valid  = 1'b1;
      acc  = 0;
      last = 0;
      for (int cyc = 0; cyc < 4 * (int'(ROUNDS) + 3); cyc++) begin
         if (out_valid) begin
            checks++;
            if (sb.size() == 0 || out_data !== sb[0]) begin
               failures++;
               $display("FAIL b2b_data got=%h exp=%h", out_data, (sb.size() != 0) ? sb[0] : 64'h0);
            end
            if (sb.size() != 0) void'(sb.pop_front());
         end
         took = in_valid && in_ready;
         if (took) begin
            sb.push_back(tea_dec(in_data, in_key));
            exp_cnt = exp_cnt + 1'b1;
            if (acc > 0) begin
               checks++;
               if (cyc - last != int'(ROUNDS) + 3) begin
                  failures++;
                  $display("FAIL b2b_interval got=%0d exp=%0d", cyc - last, ROUNDS + 3);
               end
            end
            last = cyc;
            acc++;
         end
         @(negedge clk);
         if (took) in_data = {$urandom, $urandom};
         in_valid = (acc < 3);
      end
      out_ready = 1'b0;
      checks++;
      if (acc != 3 || sb.size() != 0 || blk_cnt !== exp_cnt) begin
         failures++;
         $display("FAIL b2b_done got acc=%0d left=%0d cnt=%0d exp 3/0/%0d", acc, sb.size(), blk_cnt, exp_cnt);
      end
   endtask

   task automatic test_wrap();
      bit ok;
      logic [63:0] got;
      for (int g = 0; g < 40 && exp_cnt != '1; g++) begin
         send_block({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 5, ok);
         pop_one(100, got, ok);
         checks++;
         if (!ok || got !== sb[0]) begin
            failures++;
            $display("FAIL wrap_data got=%h ok=%0d exp=%h", got, ok, sb[0]);
         end
         void'(sb.pop_front());
      end
      checks++;
      if (blk_cnt !== {CNT_W{1'b1}}) begin
         failures++;
         $display("FAIL cnt_max got=%0d exp=%0d", blk_cnt, {CNT_W{1'b1}});
      end
      send_block({$urandom, $urandom}, '0, 5, ok);
      pop_one(100, got, ok);
      void'(sb.pop_front());
      checks++;
      if (!ok || blk_cnt !== '0) begin
         failures++;
         $display("FAIL cnt_wrap got=%0d ok=%0d exp=0", blk_cnt, ok);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_fill();
      test_simul();
      test_reset_mid();
      test_sample();
      test_back_to_back();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
